// File: rtl/sn74hc595_chain_seg8_driver.sv
// Serial driver for a chain of SN74HC595 shift registers, one per 8-segment digit.
// Captures a frame on trigger, shifts it out MSB-first, then latches it.
module sn74hc595_chain_seg8_driver #(
    parameter int DIGITS         = 3,
    parameter int CLK_DIV        = 2,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic [4*DIGITS-1:0]   nums,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic                  clk_serial,
    output logic                  data,
    output logic                  load,
    output logic                  busy,
    output logic                  done
);

    localparam int NBITS = 8 * DIGITS;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(NBITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [7:0]    INV      = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DW-1:0]     div;
    logic [BW-1:0]     bit_cnt;
    logic [NBITS-1:0]  frame;
    logic [NBITS-1:0]  encoded;
    logic              phase_end;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Encode every digit into its segment byte; digit i lands in byte i.
    always_comb begin
        encoded = '0;
        for (int i = 0; i < DIGITS; i++) begin
            encoded[8*i +: 8] = INV ^ (blank[i] ? 8'h00
                                : {dp[i], hex7(nums[4*i +: 4])});
        end
    end

    assign phase_end = (div == DIV_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: each phase lasts CLK_DIV cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (trigger) state_next = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
            SHIFT_HI: if (phase_end)
                          state_next = (bit_cnt == BIT_LAST) ? LATCH : SHIFT_LO;
            LATCH:    if (phase_end) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Divider, bit counter and frame shifter; data advances as clk_serial falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
        end else if (state == IDLE) begin
            div     <= '0;
            bit_cnt <= '0;
            if (trigger) frame <= encoded;
        end else begin
            div <= phase_end ? '0 : div + DW'(1);
            if (state == SHIFT_HI && phase_end) begin
                frame <= {frame[NBITS-2:0], 1'b0};
                if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    assign clk_serial = (state == SHIFT_HI);
    assign data       = (state == SHIFT_LO || state == SHIFT_HI) && frame[NBITS-1];
    assign load       = (state == LATCH);
    assign busy       = (state == SHIFT_LO || state == SHIFT_HI || state == LATCH);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_sn74hc595_chain_seg8_driver.sv
// Bench for sn74hc595_chain_seg8_driver: two configurations checked
// cycle by cycle against a timing/segment model derived from the frame rules.
module tb_sn74hc595_chain_seg8_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig_a, trig_b;
    logic [11:0] nums_a;
    logic [2:0]  dp_a, blank_a;
    logic [15:0] nums_b;
    logic [3:0]  dp_b, blank_b;
    logic        cs_a, dt_a, ld_a, bz_a, dn_a;
    logic        cs_b, dt_b, ld_b, bz_b, dn_b;
    logic [31:0] got;

    int tests = 0;
    int fails = 0;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    sn74hc595_chain_seg8_driver #(.DIGITS(3), .CLK_DIV(1), .SEG_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst_n(rst_n), .trigger(trig_a), .nums(nums_a), .dp(dp_a),
        .blank(blank_a), .clk_serial(cs_a), .data(dt_a), .load(ld_a),
        .busy(bz_a), .done(dn_a));

    sn74hc595_chain_seg8_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .trigger(trig_b), .nums(nums_b), .dp(dp_b),
        .blank(blank_b), .clk_serial(cs_b), .data(dt_b), .load(ld_b),
        .busy(bz_b), .done(dn_b));

    always #5 clk = ~clk;

    function automatic logic [4:0] obs(input int sel);
        if (sel == 1) return {cs_b, dt_b, ld_b, bz_b, dn_b};
        return {cs_a, dt_a, ld_a, bz_a, dn_a};
    endfunction

    task automatic set_trig(input int sel, input logic v);
        if (sel == 1) trig_b = v;
        else          trig_a = v;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic randomize_inputs();
        nums_a  = 12'($urandom);
        dp_a    = 3'($urandom);
        blank_a = 3'($urandom);
        nums_b  = 16'($urandom);
        dp_b    = 4'($urandom);
        blank_b = 4'($urandom);
    endtask

    // Entry: just after a negedge; trigger is raised in this cycle (T).
    task automatic run_frame(input int sel, input bit hold, input bit chain,
                             input bit noise, input int abort_c,
                             output logic [31:0] bits);
        int d_n, cd, nb, tot, lat, off, dones, n;
        logic [31:0] ef;
        logic [7:0]  b;
        logic [4:0]  e, o;
        logic        prev_cs, dpv, blv;
        d_n = (sel == 1) ? 4 : 3;
        cd  = (sel == 1) ? 4 : 1;
        nb  = 8 * d_n;
        tot = 16 * d_n * cd;
        lat = 1 + (16 * d_n + 1) * cd;
        ef  = '0;
        for (int d = 0; d < d_n; d++) begin
            n   = (sel == 1) ? int'(nums_b[4*d +: 4]) : int'(nums_a[4*d +: 4]);
            dpv = (sel == 1) ? dp_b[d] : dp_a[d];
            blv = (sel == 1) ? blank_b[d] : blank_a[d];
            b   = blv ? 8'h00 : (seg_tab[n] | (dpv ? 8'h80 : 8'h00));
            if (sel == 1) b = ~b;
            ef[8*d +: 8] = b;
        end
        bits    = '0;
        prev_cs = 1'b0;
        dones   = 0;
        set_trig(sel, 1'b1);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c <= lat)
                set_trig(sel, hold || (noise && (c == 5 || c == 15 || c == lat)));
            else
                set_trig(sel, chain);
            if (noise && c == 3) randomize_inputs();
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                check("async_reset", 32'(obs(sel)), 32'h0);
                repeat (2) begin
                    @(negedge clk);
                    check("reset_hold", 32'(obs(sel)), 32'h0);
                end
                rst_n = 1'b1;
                set_trig(sel, 1'b0);
                @(negedge clk);
                check("after_reset", 32'(obs(sel)), 32'h0);
                return;
            end
            off = c - 1;
            if (off < tot)
                e = {((off / cd) % 2) == 1, ef[nb - 1 - off / (2 * cd)], 1'b0, 1'b1, 1'b0};
            else if (off < tot + cd)
                e = 5'b00110;
            else if (off == tot + cd)
                e = 5'b00001;
            else
                e = 5'b00000;
            o = obs(sel);
            check("wave", 32'(o), 32'(e));
            if (o[4] && !prev_cs) bits = {bits[30:0], o[3]};
            prev_cs = o[4];
            if (o[0]) dones++;
        end
        check("done_count", 32'(dones), 32'd1);
        check("frame_bits", bits, ef);
    endtask

    initial begin
        rst_n   = 1'b0;
        trig_a  = 1'b0;
        trig_b  = 1'b0;
        nums_a  = '0; dp_a = '0; blank_a = '0;
        nums_b  = '0; dp_b = '0; blank_b = '0;
        repeat (3) @(negedge clk);
        check("reset_a", 32'(obs(0)), 32'h0);
        check("reset_b", 32'(obs(1)), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        nums_a = 12'h543;
        run_frame(0, 0, 0, 0, 0, got);
        check("bytes_543", got, 32'h006D664F);

        dp_a = 3'b010; blank_a = 3'b100;
        run_frame(0, 0, 0, 0, 0, got);
        check("dp_blank", got, 32'h0000E64F);

        dp_a = 3'b000; blank_a = 3'b000;
        run_frame(0, 0, 0, 1, 0, got);
        check("noise_bytes", got, 32'h006D664F);

        nums_a = 12'h543; dp_a = '0; blank_a = '0;
        run_frame(0, 0, 0, 0, 21, got);
        run_frame(0, 0, 0, 0, 0, got);
        check("post_reset_bytes", got, 32'h006D664F);

        nums_b = 16'hABCD; dp_b = '0; blank_b = '0;
        run_frame(1, 0, 0, 0, 0, got);
        check("bytes_abcd_al", got, 32'h8883C6A1);

        for (int r = 0; r < 4; r++) begin
            randomize_inputs();
            run_frame(0, 0, 0, 0, 0, got);
            randomize_inputs();
            run_frame(1, 0, 0, (r == 1), 0, got);
        end

        randomize_inputs();
        run_frame(0, 1, 1, 0, 0, got);
        run_frame(0, 1, 1, 0, 0, got);
        run_frame(0, 1, 0, 0, 0, got);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
